cache_sel_scheduler: RTL and testbench

CACHE_SEL_SCHEDULER -- requirements
Module: cache_sel_scheduler

---
 rtl/cache_sel_scheduler.sv | 141 ++++++++++++++
 tb/tb_cache_sel_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_sel_scheduler.sv
// Round-robin launcher for a four-branch selector: grants one requester, drives the
// selector, then waits for its synchronized fire/done handshake or aborts on timeout.
module cache_sel_scheduler #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [3:0] valid_sel,
    output logic       o_drive,
    input  logic       i_fire,
    input  logic       i_done,
    output logic       busy,
    output logic       err,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT_FIRE, WAIT_DONE} state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t                 state_reg, state_next;
    logic [1:0]             ptr_reg, ptr_next;
    logic [7:0]             timer_reg, timer_next;
    logic [7:0]             err_cnt_reg, err_cnt_next;
    logic [3:0]             gnt_reg, gnt_next;
    logic [3:0]             valid_sel_reg, valid_sel_next;
    logic                   o_drive_reg, o_drive_next;
    logic                   err_reg, err_next;
    logic [SYNC_STAGES-1:0] fire_sync_reg, done_sync_reg;
    logic                   fire_prev_reg, done_prev_reg;
    logic                   fire_evt, done_evt;
    logic [3:0]             req_rot;
    logic [1:0]             win_off, win_idx;
    logic [3:0]             win_onehot;

    assign fire_evt = fire_sync_reg[SYNC_STAGES-1] & ~fire_prev_reg;
    assign done_evt = done_sync_reg[SYNC_STAGES-1] & ~done_prev_reg;

    // Rotate requests so bit 0 of req_rot is the requester at ptr.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign req_rot[gi] = req[ptr_reg + 2'(gi)];
    end

    always_comb begin
        win_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) win_off = 2'(i);
        end
    end

    assign win_idx    = ptr_reg + win_off;
    assign win_onehot = 4'b0001 << win_idx;

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        timer_next     = timer_reg;
        err_cnt_next   = err_cnt_reg;
        gnt_next       = 4'b0000;
        valid_sel_next = valid_sel_reg;
        o_drive_next   = 1'b0;
        err_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_next     = DRIVE;
                    gnt_next       = win_onehot;
                    valid_sel_next = win_onehot;
                    ptr_next       = win_idx + 2'd1;
                end
            end
            DRIVE: begin
                state_next   = WAIT_FIRE;
                timer_next   = 8'd0;
                o_drive_next = 1'b1;
            end
            WAIT_FIRE, WAIT_DONE: begin
                timer_next = timer_reg + 8'd1;
                // Timeout wins over any event arriving in the same cycle.
                if (timer_reg == TIMER_LAST) begin
                    state_next     = IDLE;
                    valid_sel_next = 4'b0000;
                    err_next       = 1'b1;
                    if (err_cnt_reg != 8'hFF) err_cnt_next = err_cnt_reg + 8'd1;
                end else if (state_reg == WAIT_FIRE) begin
                    if (fire_evt && done_evt) begin
                        state_next     = IDLE;
                        valid_sel_next = 4'b0000;
                    end else if (fire_evt) begin
                        state_next = WAIT_DONE;
                    end
                end else if (done_evt) begin
                    state_next     = IDLE;
                    valid_sel_next = 4'b0000;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            ptr_reg       <= 2'd0;
            timer_reg     <= 8'd0;
            err_cnt_reg   <= 8'd0;
            gnt_reg       <= 4'b0000;
            valid_sel_reg <= 4'b0000;
            o_drive_reg   <= 1'b0;
            err_reg       <= 1'b0;
            fire_sync_reg <= '0;
            done_sync_reg <= '0;
            fire_prev_reg <= 1'b0;
            done_prev_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            timer_reg     <= timer_next;
            err_cnt_reg   <= err_cnt_next;
            gnt_reg       <= gnt_next;
            valid_sel_reg <= valid_sel_next;
            o_drive_reg   <= o_drive_next;
            err_reg       <= err_next;
            fire_sync_reg <= {fire_sync_reg[SYNC_STAGES-2:0], i_fire};
            done_sync_reg <= {done_sync_reg[SYNC_STAGES-2:0], i_done};
            fire_prev_reg <= fire_sync_reg[SYNC_STAGES-1];
            done_prev_reg <= done_sync_reg[SYNC_STAGES-1];
        end
    end

    assign gnt       = gnt_reg;
    assign valid_sel = valid_sel_reg;
    assign o_drive   = o_drive_reg;
    assign busy      = (state_reg != IDLE);
    assign err       = err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_cache_sel_scheduler.sv
// Directed bench for cache_sel_scheduler: grant order, handshake paths, timeout,
// spurious done and asynchronous reset mid-transaction.
module tb_cache_sel_scheduler;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] valid_sel;
    logic       o_drive;
    logic       i_fire;
    logic       i_done;
    logic       busy;
    logic       err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    cache_sel_scheduler #(
        .SYNC_STAGES(2),
        .TIMEOUT    (10)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .gnt      (gnt),
        .valid_sel(valid_sel),
        .o_drive  (o_drive),
        .i_fire   (i_fire),
        .i_done   (i_done),
        .busy     (busy),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Entered with the DUT in WAIT_FIRE and both inputs low; leaves it in IDLE.
    task automatic fire_done(input string tag);
        i_fire = 1'b1;
        step(); step(); step();
        check({tag, "_wdone_busy"}, {7'd0, busy}, 8'd1);
        i_fire = 1'b0;
        i_done = 1'b1;
        step(); step();
        check({tag, "_wdone_busy2"}, {7'd0, busy}, 8'd1);
        step();
        check({tag, "_idle_busy"}, {7'd0, busy}, 8'd0);
        check({tag, "_idle_vsel"}, {4'd0, valid_sel}, 8'h00);
        i_done = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_gnt;
        rstn   = 1'b0;
        req    = 4'b0000;
        i_fire = 1'b0;
        i_done = 1'b0;
        #12;
        check("rst_gnt", {4'd0, gnt}, 8'h00);
        check("rst_vsel", {4'd0, valid_sel}, 8'h00);
        check("rst_drive", {7'd0, o_drive}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_err", {7'd0, err}, 8'h00);
        check("rst_errcnt", err_cnt, 8'h00);
        @(negedge clk);
        rstn = 1'b1;
        step(); step();

        // Round robin with all four requesting: 0,1,2,3,0
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            step();
            check("rr_gnt", {4'd0, gnt}, {4'd0, exp_gnt});
            check("rr_vsel", {4'd0, valid_sel}, {4'd0, exp_gnt});
            step();
            check("rr_drive", {7'd0, o_drive}, 8'd1);
            if (k == 4) req = 4'b0000;
            fire_done("rr");
        end
        step(); step(); step();

        // Single request, ptr now 1
        req = 4'b0100;
        step();
        check("single_gnt", {4'd0, gnt}, 8'h04);
        check("single_vsel", {4'd0, valid_sel}, 8'h04);
        check("single_drive0", {7'd0, o_drive}, 8'd0);
        check("single_busy", {7'd0, busy}, 8'd1);
        req = 4'b0000;
        step();
        check("single_gnt_off", {4'd0, gnt}, 8'h00);
        check("single_drive1", {7'd0, o_drive}, 8'd1);
        check("single_vsel_wf", {4'd0, valid_sel}, 8'h04);
        i_fire = 1'b1;
        step();
        check("single_drive_off", {7'd0, o_drive}, 8'd0);
        step(); step();
        check("single_wdone_vsel", {4'd0, valid_sel}, 8'h04);
        i_fire = 1'b0;
        i_done = 1'b1;
        step(); step();
        check("single_hold_vsel", {4'd0, valid_sel}, 8'h04);
        step();
        check("single_idle_vsel", {4'd0, valid_sel}, 8'h00);
        check("single_idle_busy", {7'd0, busy}, 8'd0);
        i_done = 1'b0;
        step(); step(); step();

        // Simultaneous fire and done, ptr now 3 -> wraps to requester 0
        req = 4'b0001;
        step();
        check("simul_gnt", {4'd0, gnt}, 8'h01);
        req = 4'b0000;
        step();
        i_fire = 1'b1;
        i_done = 1'b1;
        step(); step();
        check("simul_wait_busy", {7'd0, busy}, 8'd1);
        step();
        check("simul_idle_busy", {7'd0, busy}, 8'd0);
        check("simul_idle_vsel", {4'd0, valid_sel}, 8'h00);
        check("simul_err", {7'd0, err}, 8'd0);
        i_fire = 1'b0;
        i_done = 1'b0;
        step(); step(); step();

        // Spurious done in WAIT_FIRE, ptr now 1
        req = 4'b0010;
        step();
        check("spur_gnt", {4'd0, gnt}, 8'h02);
        req = 4'b0000;
        step();
        i_done = 1'b1;
        step(); step(); step();
        check("spur_busy", {7'd0, busy}, 8'd1);
        check("spur_vsel", {4'd0, valid_sel}, 8'h02);
        i_done = 1'b0;
        fire_done("spur");
        step(); step(); step();

        // Timeout: no fire ever arrives, ptr now 2
        req = 4'b0100;
        step();
        check("to_gnt", {4'd0, gnt}, 8'h04);
        req = 4'b0000;
        step();
        for (int c = 0; c < 9; c++) step();
        check("to_busy_before", {7'd0, busy}, 8'd1);
        check("to_err_before", {7'd0, err}, 8'd0);
        step();
        check("to_err", {7'd0, err}, 8'd1);
        check("to_errcnt", err_cnt, 8'd1);
        check("to_busy", {7'd0, busy}, 8'd0);
        check("to_vsel", {4'd0, valid_sel}, 8'h00);
        step();
        check("to_err_pulse", {7'd0, err}, 8'd0);
        check("to_errcnt_hold", err_cnt, 8'd1);

        // Reset while in WAIT_DONE, ptr now 3
        req = 4'b0001;
        step();
        check("mrst_gnt", {4'd0, gnt}, 8'h01);
        req = 4'b0000;
        step();
        i_fire = 1'b1;
        step(); step(); step();
        check("mrst_wdone_busy", {7'd0, busy}, 8'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("mrst_gnt0", {4'd0, gnt}, 8'h00);
        check("mrst_vsel0", {4'd0, valid_sel}, 8'h00);
        check("mrst_drive0", {7'd0, o_drive}, 8'h00);
        check("mrst_busy0", {7'd0, busy}, 8'h00);
        check("mrst_err0", {7'd0, err}, 8'h00);
        check("mrst_errcnt0", err_cnt, 8'h00);
        i_fire = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        step();
        req = 4'b1000;
        step();
        check("post_gnt", {4'd0, gnt}, 8'h08);
        check("post_vsel", {4'd0, valid_sel}, 8'h08);
        req = 4'b0000;
        step();
        check("post_drive", {7'd0, o_drive}, 8'd1);
        fire_done("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
